// File: rtl/os2ip_i2osp_stream_pkg.sv
// Shared definitions for the octet-serial OS2IP / I2OSP converter.
package rsa_conv_pkg;

    localparam int unsigned OCTET_W        = 8;
    localparam int unsigned NBYTES_DEFAULT = 256;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        RES,
        CHK,
        EMIT
    } conv_state_t;

endpackage

// File: rtl/os2ip_i2osp_stream_mul_pow256.sv
// Multiply by 256^k: a byte-granular left shift of a W-bit value.
module mul_pow256 #(
    parameter int unsigned W   = 2048,
    parameter int unsigned K_W = 9
) (
    input  logic [W-1:0]   value,
    input  logic [K_W-1:0] k,
    output logic [W-1:0]   product
);

    always_comb begin
        product = value << {k, 3'b000};
    end

endmodule

// File: rtl/os2ip_i2osp_stream.sv
// Octet-serial PKCS#1 converter: OS2IP accumulation and I2OSP serialisation with
// the "integer too large" check.
module os2ip_i2osp_stream
    import rsa_conv_pkg::*;
#(
    parameter int unsigned NBYTES = NBYTES_DEFAULT,
    parameter int unsigned LEN_W  = $clog2(NBYTES + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [OCTET_W-1:0]            oct_in,
    input  logic                          oct_in_valid,
    input  logic                          oct_in_last,
    output logic                          oct_in_ready,
    output logic [OCTET_W*NBYTES-1:0]     int_out,
    output logic [LEN_W-1:0]              int_out_len,
    output logic                          int_out_err,
    output logic                          int_out_valid,
    input  logic                          int_out_ready,
    input  logic [OCTET_W*NBYTES-1:0]     int_in,
    input  logic [LEN_W-1:0]              int_in_len,
    input  logic                          int_in_valid,
    output logic                          int_in_ready,
    output logic [OCTET_W-1:0]            oct_out,
    output logic                          oct_out_valid,
    output logic                          oct_out_last,
    input  logic                          oct_out_ready,
    output logic                          i2osp_err
);

    localparam int unsigned      W    = OCTET_W * NBYTES;
    localparam logic [LEN_W-1:0] NB_L = LEN_W'(NBYTES);

    conv_state_t      state, state_n;
    logic [W-1:0]     acc;
    logic [LEN_W-1:0] cnt;
    logic             err;
    logic [W-1:0]     x_reg;
    logic [LEN_W-1:0] len_reg;
    logic [W-1:0]     sr;
    logic [LEN_W-1:0] rem;

    logic [W-1:0]     hi_mask;
    logic [W-1:0]     x_aligned;
    logic             req_bad;
    logic             oct_acc, req_acc, res_acc, out_acc;

    // Align x so its xLen-th octet from the bottom lands in the top octet of sr.
    mul_pow256 #(
        .W   (W),
        .K_W (LEN_W)
    ) u_pre_shift (
        .value   (x_reg),
        .k       (NB_L - len_reg),
        .product (x_aligned)
    );

    always_comb begin
        hi_mask = '1;
        hi_mask = hi_mask << {len_reg, 3'b000};
        req_bad = (len_reg == '0) || (len_reg > NB_L) || (|(x_reg & hi_mask));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n       = state;
        oct_in_ready  = 1'b0;
        int_in_ready  = 1'b0;
        int_out_valid = 1'b0;
        oct_out_valid = 1'b0;
        oct_out_last  = 1'b0;
        i2osp_err     = 1'b0;
        case (state)
            IDLE: begin
                oct_in_ready = 1'b1;
                int_in_ready = !oct_in_valid;
                if (oct_in_valid) begin
                    state_n = oct_in_last ? RES : ACC;
                end else if (int_in_valid) begin
                    state_n = CHK;
                end
            end
            ACC: begin
                oct_in_ready = 1'b1;
                if (oct_in_valid && oct_in_last) begin
                    state_n = RES;
                end
            end
            RES: begin
                int_out_valid = 1'b1;
                if (int_out_ready) begin
                    state_n = IDLE;
                end
            end
            CHK: begin
                i2osp_err = req_bad;
                state_n   = req_bad ? IDLE : EMIT;
            end
            EMIT: begin
                oct_out_valid = 1'b1;
                oct_out_last  = (rem == LEN_W'(1));
                if (oct_out_ready && rem == LEN_W'(1)) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Nothing handshakes or flags while reset is asserted, whatever state we are in.
        if (reset) begin
            oct_in_ready  = 1'b0;
            int_in_ready  = 1'b0;
            int_out_valid = 1'b0;
            oct_out_valid = 1'b0;
            oct_out_last  = 1'b0;
            i2osp_err     = 1'b0;
        end
    end

    assign oct_acc = oct_in_valid && oct_in_ready;
    assign req_acc = int_in_valid && int_in_ready;
    assign res_acc = int_out_valid && int_out_ready;
    assign out_acc = oct_out_valid && oct_out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            x_reg   <= '0;
            len_reg <= '0;
            sr      <= '0;
            rem     <= '0;
        end else begin
            if (oct_acc) begin
                acc <= {acc[W-OCTET_W-1:0], oct_in};
                if (cnt != NB_L) begin
                    cnt <= cnt + 1'b1;
                end
                if (acc[W-1 -: OCTET_W] != '0) begin
                    err <= 1'b1;
                end
            end
            if (res_acc) begin
                acc <= '0;
                cnt <= '0;
                err <= 1'b0;
            end
            if (req_acc) begin
                x_reg   <= int_in;
                len_reg <= int_in_len;
            end
            if (state == CHK && !req_bad) begin
                sr  <= x_aligned;
                rem <= len_reg;
            end
            if (out_acc) begin
                sr  <= sr << OCTET_W;
                rem <= rem - 1'b1;
            end
        end
    end

    assign int_out     = (state == RES)  ? acc : '0;
    assign int_out_len = (state == RES)  ? cnt : '0;
    assign int_out_err = (state == RES)  ? err : 1'b0;
    assign oct_out     = (state == EMIT) ? sr[W-1 -: OCTET_W] : '0;

endmodule

// File: tb/tb_os2ip_i2osp_stream.sv
// Directed + randomized bench for os2ip_i2osp_stream against a byte-level model.
module tb_os2ip_i2osp_stream;

    localparam int unsigned NBYTES = 256;
    localparam int unsigned LEN_W  = 9;
    localparam int unsigned W      = 8 * NBYTES;

    typedef logic [7:0] oct_q_t[$];

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       oct_in;
    logic             oct_in_valid, oct_in_last, oct_in_ready;
    logic [W-1:0]     int_out;
    logic [LEN_W-1:0] int_out_len;
    logic             int_out_err, int_out_valid, int_out_ready;
    logic [W-1:0]     int_in;
    logic [LEN_W-1:0] int_in_len;
    logic             int_in_valid, int_in_ready;
    logic [7:0]       oct_out;
    logic             oct_out_valid, oct_out_last, oct_out_ready, i2osp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    os2ip_i2osp_stream #(.NBYTES(NBYTES)) dut (
        .clk(clk), .reset(reset),
        .oct_in(oct_in), .oct_in_valid(oct_in_valid), .oct_in_last(oct_in_last),
        .oct_in_ready(oct_in_ready),
        .int_out(int_out), .int_out_len(int_out_len), .int_out_err(int_out_err),
        .int_out_valid(int_out_valid), .int_out_ready(int_out_ready),
        .int_in(int_in), .int_in_len(int_in_len), .int_in_valid(int_in_valid),
        .int_in_ready(int_in_ready),
        .oct_out(oct_out), .oct_out_valid(oct_out_valid), .oct_out_last(oct_out_last),
        .oct_out_ready(oct_out_ready), .i2osp_err(i2osp_err)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed(low64)=%0h expected(low64)=%0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Model: OS2IP value mod 2^W, and whether any dropped leading octet was nonzero.
    function automatic logic [W-1:0] model_val(input oct_q_t q);
        logic [W-1:0] v = '0;
        foreach (q[i]) v = (v << 8) | W'(q[i]);
        return v;
    endfunction

    function automatic bit model_err(input oct_q_t q);
        int drop = int'(q.size()) - int'(NBYTES);
        for (int i = 0; i < drop; i++) if (q[i] != 8'h00) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, " oct_in_ready"},  W'(oct_in_ready), '0);
        chk({tag, " int_in_ready"},  W'(int_in_ready), '0);
        chk({tag, " int_out_valid"}, W'(int_out_valid), '0);
        chk({tag, " int_out"},       int_out, '0);
        chk({tag, " int_out_len"},   W'(int_out_len), '0);
        chk({tag, " int_out_err"},   W'(int_out_err), '0);
        chk({tag, " oct_out_valid"}, W'(oct_out_valid), '0);
        chk({tag, " oct_out"},       W'(oct_out), '0);
        chk({tag, " oct_out_last"},  W'(oct_out_last), '0);
        chk({tag, " i2osp_err"},     W'(i2osp_err), '0);
    endtask

    task automatic send_oct(input logic [7:0] b, input bit last);
        int unsigned t = 0;
        oct_in = b; oct_in_last = last; oct_in_valid = 1'b1;
        #1;
        while (!oct_in_ready && t < 50) begin step(); t++; end
        if (t >= 50) chk("oct_in_ready timeout", '0, W'(1));
        chk("int_out_valid before last", W'(int_out_valid), '0);
        step();
        oct_in_valid = 1'b0; oct_in_last = 1'b0;
    endtask

    task automatic run_os2ip(input oct_q_t q, input string tag, input int hold);
        logic [W-1:0] ev = model_val(q);
        int n = int'(q.size());
        for (int i = 0; i < n; i++) send_oct(q[i], i == n - 1);
        chk({tag, " valid"}, W'(int_out_valid), W'(1));
        chk({tag, " int_out"}, int_out, ev);
        chk({tag, " len"}, W'(int_out_len), W'((n > int'(NBYTES)) ? NBYTES : n));
        chk({tag, " err"}, W'(int_out_err), W'(model_err(q)));
        for (int h = 0; h < hold; h++) begin
            step();
            chk({tag, " held int_out"}, int_out, ev);
            chk({tag, " held valid"}, W'(int_out_valid), W'(1));
            chk({tag, " held oct_in_ready"}, W'(oct_in_ready), '0);
        end
        int_out_ready = 1'b1;
        step();
        int_out_ready = 1'b0;
        chk({tag, " valid drop"}, W'(int_out_valid), '0);
        chk({tag, " back idle"}, W'(oct_in_ready), W'(1));
    endtask

    task automatic run_i2osp(input logic [W-1:0] x, input logic [LEN_W-1:0] len,
                             input string tag, input int stall_at);
        bit bad;
        int unsigned t = 0;
        logic [W-1:0] tmp;
        bad = (len == 0) || (len > NBYTES) || ((x >> (8 * int'(len))) != '0);
        int_in = x; int_in_len = len; int_in_valid = 1'b1;
        #1;
        while (!int_in_ready && t < 50) begin step(); t++; end
        if (t >= 50) chk("int_in_ready timeout", '0, W'(1));
        step();
        int_in_valid = 1'b0;
        chk({tag, " err pulse"}, W'(i2osp_err), W'(bad));
        chk({tag, " no early octet"}, W'(oct_out_valid), '0);
        step();
        chk({tag, " err one cycle"}, W'(i2osp_err), '0);
        if (bad) begin
            chk({tag, " rejected no octet"}, W'(oct_out_valid), '0);
            chk({tag, " rejected idle"}, W'(int_in_ready), W'(1));
            return;
        end
        for (int i = 0; i < int'(len); i++) begin
            int stalls = (i == stall_at) ? 3 : int'($urandom_range(0, 1));
            tmp = x >> (8 * (int'(len) - 1 - i));
            for (int s = 0; s < stalls; s++) begin
                oct_out_ready = 1'b0;
                chk({tag, " stall valid"}, W'(oct_out_valid), W'(1));
                chk({tag, " stall octet"}, W'(oct_out), W'(tmp[7:0]));
                step();
            end
            chk({tag, " valid"}, W'(oct_out_valid), W'(1));
            chk({tag, " octet"}, W'(oct_out), W'(tmp[7:0]));
            chk({tag, " last"}, W'(oct_out_last), W'(i == int'(len) - 1));
            oct_out_ready = 1'b1;
            step();
            oct_out_ready = 1'b0;
        end
        chk({tag, " done"}, W'(oct_out_valid), '0);
    endtask

    initial begin
        oct_q_t q;
        logic [W-1:0] x;
        int n, len, nb;

        reset = 1'b1;
        oct_in = '0; oct_in_valid = 1'b0; oct_in_last = 1'b0; int_out_ready = 1'b0;
        int_in = '0; int_in_len = '0; int_in_valid = 1'b0; oct_out_ready = 1'b0;
        step(); step();
        chk_all_zero("reset");
        reset = 1'b0;
        #1;
        chk("post reset oct_in_ready", W'(oct_in_ready), W'(1));
        chk("post reset int_in_ready", W'(int_in_ready), W'(1));

        q = '{8'h01, 8'h02, 8'h03};
        run_os2ip(q, "os2ip_3", 5);

        q = '{8'hA5};
        run_os2ip(q, "os2ip_1", 0);

        q = {}; q.push_back(8'h00);
        for (int i = 0; i < 256; i++) q.push_back(8'($urandom));
        run_os2ip(q, "os2ip_257_zero", 0);
        q[0] = 8'h01;
        run_os2ip(q, "os2ip_257_one", 0);

        for (int r = 0; r < 6; r++) begin
            q = {};
            n = (r < 4) ? int'($urandom_range(1, 24)) : int'($urandom_range(250, 260));
            for (int i = 0; i < n; i++)
                q.push_back((r == 5 && i < 4) ? 8'h00 : 8'($urandom));
            run_os2ip(q, "os2ip_rand", int'($urandom_range(0, 2)));
        end

        x = '0; x[23:0] = 24'h010203;
        run_i2osp(x, 9'd4, "i2osp_4", 2);
        run_i2osp(x, 9'd2, "i2osp_toolarge", -1);
        run_i2osp(x, 9'd0, "i2osp_len0", -1);
        run_i2osp(x, 9'd257, "i2osp_len257", -1);
        x = '1;
        run_i2osp(x, 9'd256, "i2osp_full", -1);

        for (int r = 0; r < 8; r++) begin
            len = int'($urandom_range(1, 40));
            nb = int'($urandom_range(0, len + 1));
            x = '0;
            for (int j = 0; j < nb; j++) x = (x << 8) | W'($urandom_range(1, 255));
            run_i2osp(x, LEN_W'(len), "i2osp_rand", -1);
        end

        // Reset in the middle of an accumulation.
        send_oct(8'h11, 1'b0);
        send_oct(8'h22, 1'b0);
        reset = 1'b1;
        step();
        chk_all_zero("reset_acc");
        reset = 1'b0;
        #1;
        chk("reset_acc idle ready", W'(oct_in_ready), W'(1));

        // Reset in the middle of an emission.
        x = '0; x[23:0] = 24'h010203;
        int_in = x; int_in_len = 9'd4; int_in_valid = 1'b1;
        step();
        int_in_valid = 1'b0;
        step();
        chk("emit started", W'(oct_out_valid), W'(1));
        oct_out_ready = 1'b1;
        step();
        oct_out_ready = 1'b0;
        reset = 1'b1;
        step();
        chk_all_zero("reset_emit");
        reset = 1'b0;
        #1;
        chk("reset_emit no octet", W'(oct_out_valid), '0);

        // Simultaneous requests in IDLE: OS2IP wins.
        oct_in = 8'h5A; oct_in_last = 1'b1; oct_in_valid = 1'b1;
        int_in = W'(5); int_in_len = 9'd1; int_in_valid = 1'b1;
        #1;
        chk("prio int_in_ready", W'(int_in_ready), '0);
        chk("prio oct_in_ready", W'(oct_in_ready), W'(1));
        step();
        oct_in_valid = 1'b0; oct_in_last = 1'b0; int_in_valid = 1'b0;
        chk("prio result valid", W'(int_out_valid), W'(1));
        chk("prio result", int_out, W'(8'h5A));
        chk("prio no i2osp", W'(oct_out_valid | i2osp_err), '0);
        int_out_ready = 1'b1;
        step();
        int_out_ready = 1'b0;
        chk("prio no octets after", W'(oct_out_valid), '0);
        chk("prio idle", W'(int_in_ready), W'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
